// File: rtl/lfsr_tone_bank.sv
// Bank of NUM_CH note channels: programmable divider, Galois LFSR and IDLE/PLAY/RELEASE envelope.
// Optional macro LFSR_TONE_LOCKUP_GUARD_EN replaces an all-zero LFSR result with the seed (or 1).
module lfsr_tone_bank #(
    parameter int NUM_CH    = 8,
    parameter int LFSR_W    = 8,
    parameter int DIV_W     = 17,
    parameter int REL_TICKS = 4,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = '1,
    parameter logic [LFSR_W-1:0] TAPS_DEFAULT = LFSR_W'(8'hB8)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          key_i,
    input  logic [NUM_CH-1:0]          mode_i,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_ch,
    input  logic [1:0]                 cfg_sel,
    input  logic [DIV_W-1:0]           cfg_data,
    output logic [NUM_CH-1:0]          tone_o,
    output logic [NUM_CH-1:0]          active_o,
    output logic [NUM_CH*LFSR_W-1:0]   lfsr_o
);

    localparam int REL_W = (REL_TICKS > 2) ? $clog2(REL_TICKS) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'((REL_TICKS > 0) ? REL_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    logic cfg_hit;
    assign cfg_hit = cfg_we && (32'(cfg_ch) < NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e            state_q, state_d;
        logic [DIV_W-1:0]  cnt_q, cnt_d;
        logic [DIV_W-1:0]  hp_q, hp_d;
        logic              sq_q, sq_d;
        logic [LFSR_W-1:0] lfsr_q, lfsr_d;
        logic [LFSR_W-1:0] seed_q, seed_d;
        logic [LFSR_W-1:0] taps_q, taps_d;
        logic [REL_W-1:0]  rel_q, rel_d;
        logic              tone_q, tone_d;
        logic              tick;
        logic              sel_me;
        logic [LFSR_W-1:0] step_raw, step_val, reload_val;

        assign sel_me = cfg_hit && (cfg_ch == 4'(c));

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            hp_d     = hp_q;
            sq_d     = sq_q;
            lfsr_d   = lfsr_q;
            seed_d   = seed_q;
            taps_d   = taps_q;
            rel_d    = rel_q;

            // Tick decision always uses the pre-write half_period and taps.
            tick     = (state_q != ST_IDLE) && (hp_q != '0) && (cnt_q >= hp_q - DIV_W'(1));
            step_raw = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
`ifdef LFSR_TONE_LOCKUP_GUARD_EN
            reload_val = (seed_q == '0) ? LFSR_W'(1) : seed_q;
            step_val   = (step_raw == '0) ? reload_val : step_raw;
`else
            reload_val = seed_q;
            step_val   = step_raw;
`endif

            if (state_q != ST_IDLE) begin
                if (hp_q == '0 || tick) cnt_d = '0;
                else                    cnt_d = cnt_q + DIV_W'(1);
                if (tick) begin
                    sq_d   = ~sq_q;
                    lfsr_d = step_val;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (key_i[c]) begin
                        state_d = ST_PLAY;
                        lfsr_d  = reload_val;
                        sq_d    = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (!key_i[c]) begin
                        if (REL_TICKS == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            rel_d   = '0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (key_i[c]) begin
                        state_d = ST_PLAY;
                    end else if (tick) begin
                        if (rel_q == REL_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            rel_d = rel_q + REL_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (sel_me) begin
                case (cfg_sel)
                    2'd0:    hp_d   = cfg_data;
                    2'd1:    seed_d = cfg_data[LFSR_W-1:0];
                    2'd2:    taps_d = cfg_data[LFSR_W-1:0];
                    default: ;
                endcase
            end

            tone_d = (state_d != ST_IDLE) && (mode_i[c] ? lfsr_d[0] : sq_d);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                hp_q    <= '0;
                sq_q    <= 1'b0;
                lfsr_q  <= SEED_DEFAULT;
                seed_q  <= SEED_DEFAULT;
                taps_q  <= TAPS_DEFAULT;
                rel_q   <= '0;
                tone_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hp_q    <= hp_d;
                sq_q    <= sq_d;
                lfsr_q  <= lfsr_d;
                seed_q  <= seed_d;
                taps_q  <= taps_d;
                rel_q   <= rel_d;
                tone_q  <= tone_d;
            end
        end

        assign tone_o[c]                    = tone_q;
        assign active_o[c]                  = (state_q != ST_IDLE);
        assign lfsr_o[c*LFSR_W +: LFSR_W]   = lfsr_q;
    end

endmodule

// File: tb/tb_lfsr_tone_bank.sv
// Directed bench for lfsr_tone_bank: square, noise, release, lockup, live reconfig and reset mid-note.
module tb_lfsr_tone_bank;
  localparam int NUM_CH = 8;
  localparam int LFSR_W = 8;
  localparam int DIV_W  = 17;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        key_i;
  logic [NUM_CH-1:0]        mode_i;
  logic                     cfg_we;
  logic [3:0]               cfg_ch;
  logic [1:0]               cfg_sel;
  logic [DIV_W-1:0]         cfg_data;
  logic [NUM_CH-1:0]        tone_o;
  logic [NUM_CH-1:0]        active_o;
  logic [NUM_CH*LFSR_W-1:0] lfsr_o;

  int n_cmp = 0;
  int n_mis = 0;

  lfsr_tone_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_i),
    .mode_i   (mode_i),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .tone_o   (tone_o),
    .active_o (active_o),
    .lfsr_o   (lfsr_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_i = '0; mode_i = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  // driver
  task automatic cfg_write(input logic [3:0] ch, input logic [1:0] sel, input logic [DIV_W-1:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    key_i = '0; mode_i = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (tone_o !== 8'h00) begin n_mis++; $display("FAIL reset_tone: observed %h required 00", tone_o); end
    n_cmp++; if (active_o !== 8'h00) begin n_mis++; $display("FAIL reset_active: observed %h required 00", active_o); end
    n_cmp++; if (lfsr_o !== {NUM_CH{8'hFF}}) begin n_mis++; $display("FAIL reset_lfsr: observed %h required all FF", lfsr_o); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_square();
    logic exp_t;
    do_reset();
    cfg_write(4'd0, 2'd0, 17'd4);
    key_i[0] = 1'b1;
    step(1);
    n_cmp++; if (active_o[0] !== 1'b1) begin n_mis++; $display("FAIL square_active: observed %b required 1", active_o[0]); end
    n_cmp++; if (tone_o[0] !== 1'b0) begin n_mis++; $display("FAIL square_tone k=0: observed %b required 0", tone_o[0]); end
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp_t = ((k / 4) % 2) == 1;
      n_cmp++; if (tone_o[0] !== exp_t) begin n_mis++; $display("FAIL square_tone k=%0d: observed %b required %b", k, tone_o[0], exp_t); end
    end
  endtask

  task automatic test_noise();
    logic [7:0] exp_l [5];
    exp_l[0] = 8'hFF; exp_l[1] = 8'hC7; exp_l[2] = 8'hDB; exp_l[3] = 8'hD5; exp_l[4] = 8'hD2;
    do_reset();
    cfg_write(4'd0, 2'd1, 17'hFF);
    cfg_write(4'd0, 2'd2, 17'hB8);
    cfg_write(4'd0, 2'd0, 17'd2);
    mode_i[0] = 1'b1;
    key_i[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(i == 0 ? 1 : 2);
      n_cmp++; if (lfsr_o[7:0] !== exp_l[i]) begin n_mis++; $display("FAIL noise_lfsr i=%0d: observed %h required %h", i, lfsr_o[7:0], exp_l[i]); end
      n_cmp++; if (tone_o[0] !== exp_l[i][0]) begin n_mis++; $display("FAIL noise_tone i=%0d: observed %b required %b", i, tone_o[0], exp_l[i][0]); end
    end
  endtask

  task automatic test_release();
    logic exp_a, exp_t;
    do_reset();
    cfg_write(4'd0, 2'd0, 17'd3);
    key_i[0] = 1'b1;
    step(1);
    step(5);
    key_i[0] = 1'b0;
    step(1);
    n_cmp++; if (active_o[0] !== 1'b1) begin n_mis++; $display("FAIL release_enter: observed %b required 1", active_o[0]); end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_a = (k < 12);
      exp_t = (k < 12) ? (((k / 3) % 2) == 1) : 1'b0;
      n_cmp++; if (active_o[0] !== exp_a) begin n_mis++; $display("FAIL release_active k=%0d: observed %b required %b", k, active_o[0], exp_a); end
      n_cmp++; if (tone_o[0] !== exp_t) begin n_mis++; $display("FAIL release_tone k=%0d: observed %b required %b", k, tone_o[0], exp_t); end
    end
    // Re-press while releasing: LFSR must continue, not reload.
    do_reset();
    cfg_write(4'd0, 2'd0, 17'd3);
    mode_i[0] = 1'b1;
    key_i[0]  = 1'b1;
    step(1);
    step(3);
    key_i[0] = 1'b0;
    step(1);
    n_cmp++; if (active_o[0] !== 1'b1) begin n_mis++; $display("FAIL repress_release_active: observed %b required 1", active_o[0]); end
    step(2);
    n_cmp++; if (lfsr_o[7:0] !== 8'hDB) begin n_mis++; $display("FAIL repress_lfsr_rel: observed %h required DB", lfsr_o[7:0]); end
    key_i[0] = 1'b1;
    step(1);
    n_cmp++; if (lfsr_o[7:0] !== 8'hDB) begin n_mis++; $display("FAIL repress_no_reload: observed %h required DB", lfsr_o[7:0]); end
    step(2);
    n_cmp++; if (lfsr_o[7:0] !== 8'hD5) begin n_mis++; $display("FAIL repress_continue: observed %h required D5", lfsr_o[7:0]); end
    n_cmp++; if (tone_o[0] !== 1'b1) begin n_mis++; $display("FAIL repress_tone: observed %b required 1", tone_o[0]); end
  endtask

  task automatic test_lockup();
    logic [7:0] exp_l;
`ifdef LFSR_TONE_LOCKUP_GUARD_EN
    exp_l = 8'h01;
`else
    exp_l = 8'h00;
`endif
    do_reset();
    cfg_write(4'd0, 2'd1, 17'h01);
    cfg_write(4'd0, 2'd2, 17'h00);
    cfg_write(4'd0, 2'd0, 17'd2);
    mode_i[0] = 1'b1;
    key_i[0]  = 1'b1;
    step(1);
    n_cmp++; if (lfsr_o[7:0] !== 8'h01) begin n_mis++; $display("FAIL lockup_load: observed %h required 01", lfsr_o[7:0]); end
    step(2);
    n_cmp++; if (lfsr_o[7:0] !== exp_l) begin n_mis++; $display("FAIL lockup_tick: observed %h required %h", lfsr_o[7:0], exp_l); end
  endtask

  task automatic test_reconfig();
    logic exp_t [6];
    exp_t[0] = 1'b0; exp_t[1] = 1'b1; exp_t[2] = 1'b1; exp_t[3] = 1'b0; exp_t[4] = 1'b0; exp_t[5] = 1'b1;
    do_reset();
    cfg_write(4'd0, 2'd0, 17'd100);
    key_i[0] = 1'b1;
    step(1);
    step(50);
    cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 2'd0; cfg_data = 17'd2;
    for (int i = 0; i < 6; i++) begin
      step(1);
      cfg_we = 1'b0;
      n_cmp++; if (tone_o[0] !== exp_t[i]) begin n_mis++; $display("FAIL reconfig_tone i=%0d: observed %b required %b", i, tone_o[0], exp_t[i]); end
    end
    // Out-of-range channel and sel=3 writes must leave channel 1 untouched.
    cfg_write(4'd9, 2'd0, 17'd1);
    cfg_write(4'd9, 2'd1, 17'h00);
    cfg_write(4'd1, 2'd3, 17'd1);
    key_i[1] = 1'b1;
    step(1);
    n_cmp++; if (active_o[1] !== 1'b1) begin n_mis++; $display("FAIL ignored_active: observed %b required 1", active_o[1]); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      n_cmp++; if (tone_o[1] !== 1'b0) begin n_mis++; $display("FAIL ignored_tone i=%0d: observed %b required 0", i, tone_o[1]); end
      n_cmp++; if (lfsr_o[15:8] !== 8'hFF) begin n_mis++; $display("FAIL ignored_lfsr i=%0d: observed %h required FF", i, lfsr_o[15:8]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_write(4'd0, 2'd0, 17'd5);
    cfg_write(4'd1, 2'd0, 17'd5);
    cfg_write(4'd2, 2'd0, 17'd5);
    key_i = 8'b0000_0111;
    step(1);
    step(6);
    n_cmp++; if (tone_o[2:0] !== 3'b111) begin n_mis++; $display("FAIL mid_pre_tone: observed %b required 111", tone_o[2:0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tone_o !== 8'h00) begin n_mis++; $display("FAIL mid_tone: observed %h required 00", tone_o); end
    n_cmp++; if (active_o !== 8'h00) begin n_mis++; $display("FAIL mid_active: observed %h required 00", active_o); end
    n_cmp++; if (lfsr_o !== {NUM_CH{8'hFF}}) begin n_mis++; $display("FAIL mid_lfsr: observed %h required all FF", lfsr_o); end
    #1;
    rst_n = 1'b1;
    step(1);
    n_cmp++; if (active_o[2:0] !== 3'b111) begin n_mis++; $display("FAIL post_active: observed %b required 111", active_o[2:0]); end
    step(3);
    n_cmp++; if (tone_o !== 8'h00) begin n_mis++; $display("FAIL post_silent: observed %h required 00", tone_o); end
    cfg_write(4'd0, 2'd0, 17'd2);
    step(2);
    n_cmp++; if (tone_o[2:0] !== 3'b001) begin n_mis++; $display("FAIL post_write_tone: observed %b required 001", tone_o[2:0]); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_noise();
    test_release();
    test_lockup();
    test_reconfig();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
